// File: rtl/eu_iqueue_pkg.sv
// Shared types for the execution-unit instruction queue.
package eu_iqueue_pkg;
  localparam int IQUEUE_DEPTH = 8;

  typedef struct packed {
    logic [3:0]  fu_op;
    logic [5:0]  rd_tag;
    logic [15:0] payload;
  } type_iqueue_entry;
endpackage

// File: rtl/eu_iqueue_if.sv
// Enqueue/dispatch/status bundle; slave = queue side, master = upstream + ALU side.
interface eu_iqueue_if
  import eu_iqueue_pkg::*;
#(
  parameter int DEPTH = IQUEUE_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) ();
  type_iqueue_entry   enq_instr_i;
  logic               enq_valid_i;
  logic               enq_ready_o;
  type_iqueue_entry   dispatched_instr_o;
  logic               dispatched_instr_valid_o;
  logic               ready_for_next_instr_i;
  logic               flush_i;
  logic [CNT_W-1:0]   count_o;
  logic               empty_o;
  logic               full_o;

  modport slave (
    input  enq_instr_i, enq_valid_i, ready_for_next_instr_i, flush_i,
    output enq_ready_o, dispatched_instr_o, dispatched_instr_valid_o,
           count_o, empty_o, full_o
  );

  modport master (
    output enq_instr_i, enq_valid_i, ready_for_next_instr_i, flush_i,
    input  enq_ready_o, dispatched_instr_o, dispatched_instr_valid_o,
           count_o, empty_o, full_o
  );
endinterface

// File: rtl/eu_iqueue_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port. Not reset.
module iqueue_mem
  import eu_iqueue_pkg::*;
#(
  parameter int DEPTH = IQUEUE_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  type_iqueue_entry i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output type_iqueue_entry o_rdata
);
  type_iqueue_entry r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/eu_iqueue.sv
// In-order instruction queue feeding the ALU dispatch port.
// Define IQUEUE_BYPASS_EN to let an empty queue forward enq_instr_i to the ALU in the same cycle.
module eu_iqueue
  import eu_iqueue_pkg::*;
#(
  parameter int DEPTH = IQUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  eu_iqueue_if.slave  iq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_cnt_nxt;
  logic             r_empty, r_full;
  logic             w_byp, w_push, w_pop;
  type_iqueue_entry w_head;

  iqueue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (iq.enq_instr_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

`ifdef IQUEUE_BYPASS_EN
  assign w_byp = r_empty && iq.enq_valid_i && !iq.flush_i;
  assign iq.dispatched_instr_o = !r_empty ? w_head : (w_byp ? iq.enq_instr_i : '0);
`else
  assign w_byp = 1'b0;
  assign iq.dispatched_instr_o = !r_empty ? w_head : '0;
`endif

  assign iq.dispatched_instr_valid_o = !r_empty || w_byp;
  assign iq.enq_ready_o              = !r_full;
  assign iq.count_o                  = r_count;
  assign iq.empty_o                  = r_empty;
  assign iq.full_o                   = r_full;

  // A bypassed entry taken by the ALU in the same cycle never occupies a slot.
  assign w_push = iq.enq_valid_i && !r_full && !iq.flush_i
                  && !(w_byp && iq.ready_for_next_instr_i);
  assign w_pop  = !r_empty && iq.ready_for_next_instr_i && !iq.flush_i;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop)      w_cnt_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_cnt_nxt = r_count - CNT_W'(1);
  end

  // Full/empty come from the count so pointer equality is never ambiguous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else if (iq.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
    end
  end
endmodule

// File: tb/tb_eu_iqueue.sv
// Directed bench for eu_iqueue with a queue-based reference model checked every cycle.
module tb_eu_iqueue;
  import eu_iqueue_pkg::*;

`ifdef IQUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   cmp_en = 1'b0;
  bit   log_en = 1'b0;

  type_iqueue_entry mq[$];
  type_iqueue_entry dlog[$];

  eu_iqueue_if iq ();

  eu_iqueue dut (.clk(clk), .reset(reset), .iq(iq));

  always #5 clk = ~clk;

  function automatic type_iqueue_entry mk(input int v);
    type_iqueue_entry e;
    e.fu_op   = 4'(v + 3);
    e.rd_tag  = 6'(v);
    e.payload = 16'(v * 257);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: in-order list of what the queue holds.
  always @(posedge clk or posedge reset) begin
    if (reset) mq.delete();
    else if (iq.flush_i) mq.delete();
    else if (!(BYP && mq.size() == 0 && iq.enq_valid_i && iq.ready_for_next_instr_i)) begin
      automatic int n = mq.size();
      if (n > 0 && iq.ready_for_next_instr_i) void'(mq.pop_front());
      if (iq.enq_valid_i && n < 8) mq.push_back(iq.enq_instr_i);
    end
  end

  always @(negedge clk) begin
    if (!reset && cmp_en) begin
      automatic int n = mq.size();
      automatic logic ev = (n > 0) || (BYP && iq.enq_valid_i && !iq.flush_i);
      automatic type_iqueue_entry ed = '0;
      if (n > 0) ed = mq[0];
      else if (ev) ed = iq.enq_instr_i;
      chk("m_count", 32'(iq.count_o), 32'(n));
      chk("m_empty", 32'(iq.empty_o), 32'(n == 0));
      chk("m_full", 32'(iq.full_o), 32'(n == 8));
      chk("m_enq_ready", 32'(iq.enq_ready_o), 32'(n < 8));
      chk("m_valid", 32'(iq.dispatched_instr_valid_o), 32'(ev));
      chk("m_data", 32'(iq.dispatched_instr_o), 32'(ed));
      if (log_en && iq.dispatched_instr_valid_o && iq.ready_for_next_instr_i)
        dlog.push_back(iq.dispatched_instr_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iq.enq_instr_i = '0;
    iq.enq_valid_i = 1'b0;
    iq.ready_for_next_instr_i = 1'b0;
    iq.flush_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset mid-operation
    iq.enq_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iq.enq_instr_i = mk(40 + i);
      step();
    end
    iq.enq_valid_i = 1'b0;
    chk("pre_reset_count", 32'(iq.count_o), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("rst_count", 32'(iq.count_o), 32'd0);
    chk("rst_empty", 32'(iq.empty_o), 32'd1);
    chk("rst_full", 32'(iq.full_o), 32'd0);
    chk("rst_enq_ready", 32'(iq.enq_ready_o), 32'd1);
    chk("rst_valid", 32'(iq.dispatched_instr_valid_o), 32'd0);
    chk("rst_data", 32'(iq.dispatched_instr_o), 32'd0);
    step();
    reset = 1'b0;

    // Fill to full with ALU stalled, then a 9th attempt
    iq.ready_for_next_instr_i = 1'b0;
    iq.enq_valid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      iq.enq_instr_i = mk(i);
      step();
      if (i == 1) chk("lat_valid", 32'(iq.dispatched_instr_valid_o), 32'd1);
    end
    chk("fill_count", 32'(iq.count_o), 32'd8);
    chk("fill_full", 32'(iq.full_o), 32'd1);
    chk("fill_enq_ready", 32'(iq.enq_ready_o), 32'd0);
    iq.enq_instr_i = mk(99);
    step();
    iq.enq_valid_i = 1'b0;
    chk("ninth_count", 32'(iq.count_o), 32'd8);

    // Stall: head held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_data", 32'(iq.dispatched_instr_o), 32'(mk(1)));
      chk("stall_valid", 32'(iq.dispatched_instr_valid_o), 32'd1);
    end

    // Drain to 3, then simultaneous enq+deq
    iq.ready_for_next_instr_i = 1'b1;
    repeat (5) step();
    chk("drain_count", 32'(iq.count_o), 32'd3);
    chk("drain_head", 32'(iq.dispatched_instr_o), 32'(mk(6)));
    iq.enq_valid_i = 1'b1;
    iq.enq_instr_i = mk(9);
    step();
    chk("simul_count", 32'(iq.count_o), 32'd3);
    chk("simul_head", 32'(iq.dispatched_instr_o), 32'(mk(7)));

    // Order across pointer wrap
    dlog.delete();
    log_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      iq.enq_instr_i = mk(8'h11 + i);
      step();
    end
    iq.enq_valid_i = 1'b0;
    begin
      int cyc = 0;
      while (!iq.empty_o && cyc < 40) begin
        step();
        cyc++;
      end
      chk("drain_bound", 32'(iq.empty_o), 32'd1);
    end
    log_en = 1'b0;
    chk("order_len", 32'(dlog.size()), 32'd15);
    begin
      int exp_v[15];
      exp_v[0] = 7; exp_v[1] = 8; exp_v[2] = 9;
      for (int i = 0; i < 12; i++) exp_v[3 + i] = 8'h11 + i;
      for (int i = 0; i < 15; i++)
        if (i < dlog.size()) chk("order_item", 32'(dlog[i]), 32'(mk(exp_v[i])));
    end

    // Flush at count 5 with concurrent enq
    iq.ready_for_next_instr_i = 1'b0;
    iq.enq_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iq.enq_instr_i = mk(8'h21 + i);
      step();
    end
    chk("pre_flush_count", 32'(iq.count_o), 32'd5);
    iq.flush_i = 1'b1;
    iq.ready_for_next_instr_i = 1'b1;
    iq.enq_instr_i = mk(8'h2F);
    step();
    iq.flush_i = 1'b0;
    iq.enq_valid_i = 1'b0;
    chk("flush_count", 32'(iq.count_o), 32'd0);
    chk("flush_valid", 32'(iq.dispatched_instr_valid_o), 32'd0);

    // Empty queue, enq with ALU ready
    iq.enq_valid_i = 1'b1;
    iq.enq_instr_i = mk(8'h33);
    #2;
`ifdef IQUEUE_BYPASS_EN
    chk("byp_valid", 32'(iq.dispatched_instr_valid_o), 32'd1);
    chk("byp_data", 32'(iq.dispatched_instr_o), 32'(mk(8'h33)));
`else
    chk("nobyp_valid", 32'(iq.dispatched_instr_valid_o), 32'd0);
`endif
    step();
    iq.enq_valid_i = 1'b0;
`ifdef IQUEUE_BYPASS_EN
    chk("byp_count", 32'(iq.count_o), 32'd0);
    chk("byp_after_valid", 32'(iq.dispatched_instr_valid_o), 32'd0);
`else
    chk("nobyp_count", 32'(iq.count_o), 32'd1);
    chk("nobyp_data", 32'(iq.dispatched_instr_o), 32'(mk(8'h33)));
`endif
    repeat (3) step();
    chk("end_empty", 32'(iq.empty_o), 32'd1);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
